tlc_phase_sched: RTL and testbench

TLC_PHASE_SCHED -- requirements
Module: tlc_phase_sched

---
 rtl/tlc_pkg.sv | 29 ++
 rtl/tlc_rr_arb.sv | 22 ++
 rtl/tlc_phase_sched.sv | 121 ++++++++++++
 tb/tb_tlc_phase_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light phase scheduler: state encoding,
// lamp codes, approach count and the lamp-field builder.
package tlc_pkg;
  localparam int NUM_APP = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Only the granted approach can ever show a non-red aspect.
  function automatic logic [3*NUM_APP-1:0] lamp_field(input state_e st, input logic [1:0] id);
    logic [3*NUM_APP-1:0] f;
    for (int i = 0; i < NUM_APP; i++) begin
      f[3*i +: 3] = LAMP_RED;
      if (2'(i) == id) begin
        if (st == ST_GREEN)       f[3*i +: 3] = LAMP_GRN;
        else if (st == ST_YELLOW) f[3*i +: 3] = LAMP_YEL;
      end
    end
    return f;
  endfunction
endpackage

// File: rtl/tlc_rr_arb.sv
// Combinational round-robin picker: first set request searching upward from
// ptr_i+1 (mod 4); ptr_i itself has lowest priority.
module tlc_rr_arb
  import tlc_pkg::*;
(
  input  logic [NUM_APP-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [1:0]         id_o,
  output logic               vld_o
);
  always_comb begin
    id_o  = '0;
    vld_o = 1'b0;
    // Walk from farthest to nearest so the nearest hit overwrites.
    for (int k = NUM_APP; k >= 1; k--) begin
      if (req_i[ptr_i + 2'(k)]) begin
        id_o  = ptr_i + 2'(k);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tlc_phase_sched.sv
// Four-approach traffic signal scheduler: round-robin greens with min/max
// timing, yellow and all-red clearance, and emergency preemption.
module tlc_phase_sched
  import tlc_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YEL_CYC   = 2,
  parameter int CLR_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic        emerg,
  input  logic [1:0]  emerg_id,
  output logic [11:0] lamp,
  output logic        grant_vld,
  output logic [1:0]  grant_id,
  output logic [3:0]  req_ack
);
  localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_M1  = 8'(YEL_CYC - 1);
  localparam logic [7:0] CLR_M1  = 8'(CLR_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  gid_q, gid_d;
  logic [11:0] lamp_q;
  logic        vld_q;
  logic [3:0]  ack_q;
  logic [3:0]  arb_req;
  logic [1:0]  arb_id;
  logic        arb_vld;
  logic        others;
  logic        enter_grn;

  assign arb_req = pend_q | req;

  tlc_rr_arb u_arb (
    .req_i (arb_req),
    .ptr_i (gid_q),
    .id_o  (arb_id),
    .vld_o (arb_vld)
  );

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    others  = |(pend_q & ~(4'b0001 << gid_q));
    case (state_q)
      ST_IDLE: begin
        if (emerg) begin
          state_d = ST_GREEN;
          gid_d   = emerg_id;
        end else if (arb_vld) begin
          state_d = ST_GREEN;
          gid_d   = arb_id;
        end
      end
      ST_GREEN: begin
        // Emergency for our own approach pins green, even past the cap.
        if (emerg) begin
          if (emerg_id != gid_q) state_d = ST_YELLOW;
        end else if (others && ((timer_q >= GMIN_M1 && !req[gid_q]) || timer_q >= GMAX_M1)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: if (timer_q == YEL_M1) state_d = ST_ALLRED;
      ST_ALLRED: begin
        if (timer_q == CLR_M1) begin
          if (emerg) begin
            state_d = ST_GREEN;
            gid_d   = emerg_id;
          end else if (arb_vld) begin
            state_d = ST_GREEN;
            gid_d   = arb_id;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enter_grn = (state_d == ST_GREEN) && (state_q != ST_GREEN);
    // Saturate so a long rest in green still satisfies the min/max tests.
    timer_d = (state_d != state_q) ? 8'd0 :
              (timer_q == 8'hFF)   ? timer_q : timer_q + 8'd1;

    pend_d = pend_q | req;
    if (state_q == ST_GREEN) pend_d[gid_q] = pend_q[gid_q];
    if (enter_grn)           pend_d[gid_d] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      gid_q   <= '0;
      lamp_q  <= lamp_field(ST_IDLE, 2'd0);
      vld_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      gid_q   <= gid_d;
      lamp_q  <= lamp_field(state_d, gid_d);
      vld_q   <= (state_d == ST_GREEN) || (state_d == ST_YELLOW);
      ack_q   <= enter_grn ? (4'b0001 << gid_d) : 4'b0000;
    end
  end

  assign lamp      = lamp_q;
  assign grant_vld = vld_q;
  assign grant_id  = gid_q;
  assign req_ack   = ack_q;
endmodule

// File: tb/tb_tlc_phase_sched.sv
// Directed self-checking bench for tlc_phase_sched at default timing
// (GREEN_MIN=4, GREEN_MAX=10, YEL_CYC=2, CLR_CYC=1).
module tb_tlc_phase_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        emerg;
  logic [1:0]  emerg_id;
  logic [11:0] lamp;
  logic        grant_vld;
  logic [1:0]  grant_id;
  logic [3:0]  req_ack;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [11:0] ALL_RED = 12'b100100100100;

  always #5 clk = ~clk;

  tlc_phase_sched #(
    .GREEN_MIN (4),
    .GREEN_MAX (10),
    .YEL_CYC   (2),
    .CLR_CYC   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .emerg     (emerg),
    .emerg_id  (emerg_id),
    .lamp      (lamp),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .req_ack   (req_ack)
  );

  // Expected lamp word: ph 0=all red, 1=yellow on id, 2=green on id.
  function automatic logic [11:0] lf(input int ph, input int id);
    logic [11:0] l;
    l = ALL_RED;
    if (ph == 1)      l[3*id +: 3] = 3'b010;
    else if (ph == 2) l[3*id +: 3] = 3'b001;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; emerg = 1'b0; emerg_id = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; emerg = 1'b0; emerg_id = '0;
    tick(); tick();
    n_tests++; if (lamp !== ALL_RED) begin n_fail++; $display("FAIL reset_lamp got %b exp %b", lamp, ALL_RED); end
    n_tests++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", grant_vld); end
    n_tests++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b exp 0000", req_ack); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_gid got %0d exp 0", grant_id); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit bad;
    do_reset();
    tick(); tick();
    n_tests++; if (lamp !== ALL_RED || grant_vld !== 1'b0) begin n_fail++; $display("FAIL idle_red got %b vld %b", lamp, grant_vld); end
    req = 4'b0100; tick(); req = '0;
    n_tests++; if (lamp !== lf(2, 2)) begin n_fail++; $display("FAIL single_lamp got %b exp %b", lamp, lf(2, 2)); end
    n_tests++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack got %b exp 0100", req_ack); end
    n_tests++; if (grant_id !== 2'd2 || grant_vld !== 1'b1) begin n_fail++; $display("FAIL single_gid got %0d vld %b exp 2 1", grant_id, grant_vld); end
    tick();
    n_tests++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse got %b exp 0000", req_ack); end
    bad = 1'b0;
    for (int i = 0; i < 55; i++) begin
      if (lamp !== lf(2, 2)) bad = 1'b1;
      tick();
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL single_rest got %b exp %b", lamp, lf(2, 2)); end
  endtask

  task automatic test_min_green();
    logic [11:0] el [0:7];
    el[0] = lf(2, 1); el[1] = lf(2, 1); el[2] = lf(2, 1); el[3] = lf(2, 1);
    el[4] = lf(1, 1); el[5] = lf(1, 1); el[6] = ALL_RED;  el[7] = lf(2, 0);
    do_reset();
    req = 4'b0010; tick(); req = '0;
    for (int i = 0; i < 8; i++) begin
      req = (i == 1) ? 4'b0001 : 4'b0000;
      n_tests++; if (lamp !== el[i]) begin n_fail++; $display("FAIL min_green t+%0d got %b exp %b", i, lamp, el[i]); end
      if (i == 6) begin
        n_tests++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL min_green_allred_vld got %b exp 0", grant_vld); end
      end
      if (i == 7) begin
        n_tests++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL min_green_ack got %b exp 0001", req_ack); end
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_cap();
    logic [11:0] e;
    do_reset();
    req = 4'b1010; tick(); req = 4'b0010;
    for (int i = 0; i < 14; i++) begin
      e = (i <= 9) ? lf(2, 1) : (i <= 11) ? lf(1, 1) : (i == 12) ? ALL_RED : lf(2, 3);
      n_tests++; if (lamp !== e) begin n_fail++; $display("FAIL cap c%0d got %b exp %b", i, lamp, e); end
      if (i < 13) tick();
    end
    n_tests++; if (req_ack !== 4'b1000 || grant_id !== 2'd3) begin n_fail++; $display("FAIL cap_next got ack %b gid %0d exp 1000 3", req_ack, grant_id); end
    req = '0;
  endtask

  task automatic test_rr();
    do_reset();
    req = 4'b0100; tick(); req = '0;
    emerg = 1'b1; emerg_id = 2'd0; tick(); emerg = 1'b0;
    n_tests++; if (lamp !== lf(1, 2)) begin n_fail++; $display("FAIL rr_preyel got %b exp %b", lamp, lf(1, 2)); end
    tick(); tick(); tick(); tick();
    n_tests++; if (lamp !== ALL_RED || grant_vld !== 1'b0 || grant_id !== 2'd2) begin
      n_fail++; $display("FAIL rr_idle got %b vld %b gid %0d exp %b 0 2", lamp, grant_vld, grant_id, ALL_RED);
    end
    req = 4'b1001; tick(); req = '0;
    n_tests++; if (lamp !== lf(2, 3) || req_ack !== 4'b1000) begin n_fail++; $display("FAIL rr_first got %b ack %b exp %b 1000", lamp, req_ack, lf(2, 3)); end
    for (int i = 0; i < 7; i++) tick();
    n_tests++; if (lamp !== lf(2, 0) || req_ack !== 4'b0001) begin n_fail++; $display("FAIL rr_second got %b ack %b exp %b 0001", lamp, req_ack, lf(2, 0)); end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0001; tick(); req = 4'b0010;
    n_tests++; if (lamp !== lf(2, 0)) begin n_fail++; $display("FAIL pre_g0 got %b exp %b", lamp, lf(2, 0)); end
    tick(); req = '0; emerg = 1'b1; emerg_id = 2'd2;
    tick(); emerg_id = 2'd3;
    n_tests++; if (lamp !== lf(1, 0)) begin n_fail++; $display("FAIL pre_yel got %b exp %b", lamp, lf(1, 0)); end
    tick(); tick(); emerg_id = 2'd2;
    n_tests++; if (lamp !== ALL_RED) begin n_fail++; $display("FAIL pre_allred got %b exp %b", lamp, ALL_RED); end
    tick(); emerg = 1'b0;
    n_tests++; if (lamp !== lf(2, 2) || req_ack !== 4'b0100) begin n_fail++; $display("FAIL pre_g2 got %b ack %b exp %b 0100", lamp, req_ack, lf(2, 2)); end
    for (int i = 0; i < 7; i++) tick();
    n_tests++; if (lamp !== lf(2, 1) || req_ack !== 4'b0010) begin n_fail++; $display("FAIL pre_skipped got %b ack %b exp %b 0010", lamp, req_ack, lf(2, 1)); end
  endtask

  task automatic test_emerg_hold();
    bit bad;
    do_reset();
    req = 4'b0010; tick(); req = 4'b1000; emerg = 1'b1; emerg_id = 2'd1;
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (lamp !== lf(2, 1)) bad = 1'b1;
      tick(); req = '0;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL hold_green got %b exp %b", lamp, lf(2, 1)); end
    emerg = 1'b0; tick();
    n_tests++; if (lamp !== lf(1, 1)) begin n_fail++; $display("FAIL hold_release got %b exp %b", lamp, lf(1, 1)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; tick(); req = '0; tick();
    rst = 1'b1; tick();
    n_tests++; if (lamp !== ALL_RED || grant_vld !== 1'b0 || grant_id !== 2'd0 || req_ack !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid got %b vld %b gid %0d ack %b", lamp, grant_vld, grant_id, req_ack);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_min_green();
    test_cap();
    test_rr();
    test_preempt();
    test_emerg_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
